// File: rtl/packet_arbiter_pkg.sv
// Shared types and helpers for packet_arbiter: FSM state encoding and credit counter sizing.
package packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int MAX_ARBITER_WIDTH = 16;
  localparam int MAX_CREDIT_DEPTH  = 15;

  // Bits needed to hold 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_pick.sv
// Round-robin winner selection: lowest request inside the priority mask, else lowest request overall.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_request,
  input  logic [N-1:0] i_pr,
  output logic [N-1:0] o_winner
);

  logic [N-1:0] w_masked;
  logic [N-1:0] w_pool;

  assign w_masked = i_request & i_pr;
  assign w_pool   = (|w_masked) ? w_masked : i_request;
  // Two's-complement trick isolates the lowest set bit.
  assign o_winner = w_pool & (~w_pool + N'(1));

endmodule

// File: rtl/packet_arbiter.sv
// Wormhole packet arbiter: round-robin pick in IDLE, owner held until tail in LOCKED.
// Optional downstream credit counter enabled by `define PACKET_ARBITER_CREDIT_EN.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int ARBITER_WIDTH = 4,
  parameter int CREDIT_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ARBITER_WIDTH-1:0] request,
  input  logic [ARBITER_WIDTH-1:0] tail,
  input  logic                     credit_in,
  output logic [ARBITER_WIDTH-1:0] grant,
  output logic                     any_grant,
  output logic                     locked
);

  localparam int IW = (ARBITER_WIDTH > 1) ? $clog2(ARBITER_WIDTH) : 1;

  state_e                   r_state;
  logic [IW-1:0]            r_owner;
  logic [ARBITER_WIDTH-1:0] r_pr;
  logic [ARBITER_WIDTH-1:0] w_pick;
  logic [IW-1:0]            w_gidx;
  logic                     w_avail;
  logic                     w_done;

`ifdef PACKET_ARBITER_CREDIT_EN
  localparam int CW = cred_w(CREDIT_DEPTH);
  logic [CW-1:0] r_credits;

  // Reset gates avail so grant is forced low while reset is held.
  assign w_avail = reset && (r_credits != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credits <= CW'(CREDIT_DEPTH);
    end else if (any_grant && !credit_in) begin
      r_credits <= r_credits - CW'(1);
    end else if (!any_grant && credit_in && (r_credits != CW'(CREDIT_DEPTH))) begin
      r_credits <= r_credits + CW'(1);
    end
  end
`else
  logic w_unused_credit;
  assign w_unused_credit = credit_in;
  assign w_avail         = reset;
`endif

  rr_pick #(.N(ARBITER_WIDTH)) u_pick (
    .i_request (request),
    .i_pr      (r_pr),
    .o_winner  (w_pick)
  );

  always_comb begin
    grant = '0;
    if (w_avail) begin
      if (r_state == IDLE) grant = w_pick;
      else if (request[r_owner]) grant[r_owner] = 1'b1;
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < ARBITER_WIDTH; i++)
      if (grant[i]) w_gidx = IW'(i);
  end

  assign any_grant = |grant;
  assign w_done    = any_grant && tail[w_gidx];
  assign locked    = (r_state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_pr    <= '1;
    end else begin
      if (r_state == IDLE) begin
        if (any_grant && !tail[w_gidx]) begin
          r_state <= LOCKED;
          r_owner <= w_gidx;
        end
      end else if (w_done) begin
        r_state <= IDLE;
      end
      // Completing requester drops to lowest priority; everyone above it goes first next time.
      if (w_done)
        for (int i = 0; i < ARBITER_WIDTH; i++)
          r_pr[i] <= (i > int'(w_gidx));
    end
  end

endmodule
